// File: rtl/gowin_tl_rx_adapter.sv
// rtl/gowin_tl_rx_adapter.sv - Gowin PCIe TL RX stream to RIFFA RX TLP bridge with store-and-forward packet FIFO
//
// Ports:
//   CLK, RST                  single clock, asynchronous active-high reset
//   TL_RX_*                   controller transaction-layer RX stream (SOP/EOP/DATA/VALID/BARDEC/ERR in, WAIT out)
//   RX_TLP*                   RIFFA RX TLP interface, first-word-fall-through, READY handshake
//   DROP_COUNT                number of TLPs discarded (errored, unclaimed, truncated, overflowed), saturating
//   OVERFLOW                  sticky flag, set when a beat arrives while the FIFO is full
module gowin_tl_rx_adapter #(
    parameter int          C_PCI_DATA_WIDTH = 256,
    parameter int          C_FIFO_DEPTH     = 64,
    parameter int          C_WAIT_SLACK     = 4,
    parameter logic [5:0]  C_BAR_MASK       = 6'b000001
) (
    input  logic                                        CLK,
    input  logic                                        RST,
    input  logic                                        TL_RX_SOP,
    input  logic                                        TL_RX_EOP,
    input  logic [C_PCI_DATA_WIDTH-1:0]                 TL_RX_DATA,
    input  logic [C_PCI_DATA_WIDTH/32-1:0]              TL_RX_VALID,
    input  logic [5:0]                                  TL_RX_BARDEC,
    input  logic [7:0]                                  TL_RX_ERR,
    output logic                                        TL_RX_WAIT,
    output logic [C_PCI_DATA_WIDTH-1:0]                 RX_TLP,
    output logic                                        RX_TLP_VALID,
    input  logic                                        RX_TLP_READY,
    output logic                                        RX_TLP_START_FLAG,
    output logic [$clog2(C_PCI_DATA_WIDTH/32)-1:0]      RX_TLP_START_OFFSET,
    output logic                                        RX_TLP_END_FLAG,
    output logic [$clog2(C_PCI_DATA_WIDTH/32)-1:0]      RX_TLP_END_OFFSET,
    output logic [15:0]                                 DROP_COUNT,
    output logic                                        OVERFLOW
);

    localparam int NDW = C_PCI_DATA_WIDTH / 32;
    localparam int OW  = $clog2(NDW);
    localparam int AW  = $clog2(C_FIFO_DEPTH);
    localparam int PW  = AW + 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(C_FIFO_DEPTH);
    localparam logic [PW-1:0] SLACK_P = PW'(C_WAIT_SLACK);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t state;

    // wr_ptr runs ahead over the packet being collected; commit_ptr marks the
    // end of the last complete accepted packet, which is all the reader sees.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] pkt_start;
    logic [PW-1:0] rd_ptr;

    logic [C_PCI_DATA_WIDTH-1:0] mem_data [C_FIFO_DEPTH];
    logic                        mem_sop  [C_FIFO_DEPTH];
    logic                        mem_eop  [C_FIFO_DEPTH];
    logic [OW-1:0]               mem_eoff [C_FIFO_DEPTH];

    logic          beat;
    logic          beat_err;
    logic          is_cpl;
    logic          accept;
    logic          in_pkt;
    logic          full;
    logic [PW-1:0] occupancy;
    logic [OW-1:0] beat_eoff;

    logic          wr_en;
    logic [PW-1:0] base;
    logic [PW-1:0] nxt_wr;
    logic [PW-1:0] nxt_commit;
    logic [PW-1:0] nxt_pkt;
    state_t        nxt_state;
    logic [1:0]    drop_inc;
    logic          ovf_set;
    logic [16:0]   cnt_sum;
    logic          rd_fire;

    assign beat      = |TL_RX_VALID;
    assign beat_err  = |TL_RX_ERR;
    // Cpl/CplD carry type 5'b0101x and are routed by requester ID, not by BAR.
    assign is_cpl    = (TL_RX_DATA[28:25] == 4'b0101);
    assign accept    = !beat_err && (is_cpl || |(TL_RX_BARDEC & C_BAR_MASK));
    assign in_pkt    = (state == S_PASS);
    assign occupancy = wr_ptr - rd_ptr;
    // Uses the pre-read occupancy: a read in the same cycle does not make room.
    assign full      = (occupancy == DEPTH_P);

    always_comb begin
        beat_eoff = '0;
        for (int i = 0; i < NDW; i++) begin
            if (TL_RX_VALID[i]) begin
                beat_eoff = OW'(i);
            end
        end
    end

    always_comb begin
        wr_en      = 1'b0;
        base       = wr_ptr;
        nxt_wr     = wr_ptr;
        nxt_commit = commit_ptr;
        nxt_pkt    = pkt_start;
        nxt_state  = state;
        drop_inc   = 2'd0;
        ovf_set    = 1'b0;
        if (beat) begin
            if (full) begin
                ovf_set   = 1'b1;
                nxt_wr    = in_pkt ? pkt_start : wr_ptr;
                if (in_pkt || TL_RX_SOP) begin
                    drop_inc = 2'd1;
                end
                nxt_state = TL_RX_EOP ? S_IDLE : S_DROP;
            end else if (TL_RX_SOP) begin
                // A SOP inside an open packet truncates it; the new TLP then
                // starts where the truncated one did.
                if (in_pkt) begin
                    base     = pkt_start;
                    drop_inc = 2'd1;
                end
                if (accept) begin
                    wr_en   = 1'b1;
                    nxt_pkt = base;
                    nxt_wr  = base + PTR_ONE;
                    if (TL_RX_EOP) begin
                        nxt_commit = base + PTR_ONE;
                        nxt_state  = S_IDLE;
                    end else begin
                        nxt_state  = S_PASS;
                    end
                end else begin
                    nxt_wr    = base;
                    drop_inc  = drop_inc + 2'd1;
                    nxt_state = TL_RX_EOP ? S_IDLE : S_DROP;
                end
            end else if (in_pkt) begin
                if (beat_err) begin
                    nxt_wr    = pkt_start;
                    drop_inc  = 2'd1;
                    nxt_state = TL_RX_EOP ? S_IDLE : S_DROP;
                end else begin
                    wr_en  = 1'b1;
                    nxt_wr = wr_ptr + PTR_ONE;
                    if (TL_RX_EOP) begin
                        nxt_commit = wr_ptr + PTR_ONE;
                        nxt_state  = S_IDLE;
                    end
                end
            end else if (state == S_DROP && TL_RX_EOP) begin
                nxt_state = S_IDLE;
            end
        end
    end

    assign cnt_sum = {1'b0, DROP_COUNT} + {15'd0, drop_inc};
    assign rd_fire = RX_TLP_VALID && RX_TLP_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_start  <= '0;
            rd_ptr     <= '0;
            TL_RX_WAIT <= 1'b0;
            DROP_COUNT <= 16'd0;
            OVERFLOW   <= 1'b0;
        end else begin
            state      <= nxt_state;
            wr_ptr     <= nxt_wr;
            commit_ptr <= nxt_commit;
            pkt_start  <= nxt_pkt;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            TL_RX_WAIT <= ((DEPTH_P - occupancy) <= SLACK_P);
            DROP_COUNT <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (ovf_set) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    // Storage carries no reset; visibility is governed entirely by the pointers.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_data[base[AW-1:0]] <= TL_RX_DATA;
            mem_sop[base[AW-1:0]]  <= TL_RX_SOP;
            mem_eop[base[AW-1:0]]  <= TL_RX_EOP;
            mem_eoff[base[AW-1:0]] <= beat_eoff;
        end
    end

    assign RX_TLP_VALID        = (rd_ptr != commit_ptr);
    assign RX_TLP              = mem_data[rd_ptr[AW-1:0]];
    assign RX_TLP_START_FLAG   = RX_TLP_VALID && mem_sop[rd_ptr[AW-1:0]];
    assign RX_TLP_END_FLAG     = RX_TLP_VALID && mem_eop[rd_ptr[AW-1:0]];
    assign RX_TLP_END_OFFSET   = RX_TLP_VALID ? mem_eoff[rd_ptr[AW-1:0]] : '0;
    assign RX_TLP_START_OFFSET = '0;

endmodule

// File: doc/gowin_tl_rx_adapter.md
Name: gowin_tl_rx_adapter

Overview:
Receive-side bridge between the Gowin PCIe controller transaction-layer RX stream and the RIFFA RX TLP engine interface, parametrised in data width and buffer depth.
- Store-and-forward packet FIFO with commit/rewind, so errored, unclaimed, truncated or overflowed TLPs never reach RIFFA.
- Drives the controller's RX wait from FIFO occupancy; counts discarded TLPs.
- Sits between SerDes_Top TL RX ports and the RIFFA endpoint wrapper.

Parameters:
C_PCI_DATA_WIDTH, 256, beat width in bits; legal 64, 128, 256.
C_FIFO_DEPTH, 64, beats stored; power of two, at least the largest TLP in beats plus C_WAIT_SLACK.
C_WAIT_SLACK, 4, free beats remaining at which TL_RX_WAIT asserts.
C_BAR_MASK, 6'b000001, BARs whose request TLPs are accepted.

Ports:
CLK  in  1  single clock; TL and RIFFA side.
RST  in  1  asynchronous active-high reset.
TL_RX_SOP  in  1  first beat of TLP; header DW0 in bits [31:0].
TL_RX_EOP  in  1  last beat of TLP.
TL_RX_DATA  in  C_PCI_DATA_WIDTH  beat data, DW0 in LSBs.
TL_RX_VALID  in  C_PCI_DATA_WIDTH/32  per-dword valid; beat present when any bit set.
TL_RX_BARDEC  in  6  BAR hit, sampled on SOP beat.
TL_RX_ERR  in  8  nonzero = beat errored.
TL_RX_WAIT  out  1  backpressure to controller.
RX_TLP  out  C_PCI_DATA_WIDTH  output beat.
RX_TLP_VALID  out  1  output beat valid.
RX_TLP_READY  in  1  consumer accepts beat.
RX_TLP_START_FLAG  out  1  beat holds TLP start.
RX_TLP_START_OFFSET  out  clog2(W/32)  start dword; always 0.
RX_TLP_END_FLAG  out  1  beat holds TLP end.
RX_TLP_END_OFFSET  out  clog2(W/32)  last valid dword index.
DROP_COUNT  out  16  discarded TLPs, saturates at 16'hFFFF.
OVERFLOW  out  1  sticky; set on any beat arriving with FIFO full.

Behaviour:
- Reset (async): wr_ptr, commit_ptr, pkt_start, rd_ptr = 0; state IDLE; TL_RX_WAIT, RX_TLP_VALID, DROP_COUNT, OVERFLOW = 0; flags/offsets 0. Pointers clog2(DEPTH)+1 bits, wrap naturally.
- Entry = data + sop + eop + end offset (highest set TL_RX_VALID bit).
- Accept check: request TLP (DW0[28:24] not 5'b0101x) needs |(BARDEC & C_BAR_MASK) and ERR==0. Completions (Cpl/CplD) ignore BARDEC.
- States:
  - IDLE: SOP beat accepted -> write, pkt_start<=wr_ptr; eop ? commit, stay : PASS. Rejected SOP -> DROP_COUNT+1; eop ? stay : DROP. Non-SOP beat ignored, not counted.
  - PASS: ERR nonzero -> wr_ptr<=pkt_start, count, eop ? IDLE : DROP. New SOP without prior EOP -> rewind, count, then treat beat as IDLE SOP in the same cycle. EOP clean -> write, commit_ptr<=wr_ptr+1, IDLE.
  - DROP: discard beats until EOP -> IDLE. SOP in DROP handled as IDLE SOP.
- Full (wr_ptr-rd_ptr == DEPTH, pre-read value; same-cycle read does not free space): incoming beat sets OVERFLOW, rewinds, counts, -> DROP (IDLE if eop).
- TL_RX_WAIT registered: 1 when DEPTH-(wr_ptr-rd_ptr) <= C_WAIT_SLACK, evaluated each cycle.
- Output FWFT, combinational read: RX_TLP_VALID = rd_ptr != commit_ptr. Only committed beats visible. EOP beat written at edge N -> valid in cycle after N. rd_ptr advances on VALID && READY. Flags/offsets held 0 when VALID low.
- Reset mid-packet: partial packet lost; nothing delivered from it after release.

Test Plan:
- 3DW MRd, VALID=8'h07, SOP+EOP, BARDEC=6'b000001, READY=1 -> next cycle VALID=1, START_FLAG=1, START_OFFSET=0, END_FLAG=1, END_OFFSET=2; VALID=0 following cycle.
- 3-beat MWr with ERR=8'h01 on beat 2 -> no output beats, DROP_COUNT=1, FIFO occupancy 0.
- CplD (DW0[28:24]=5'b01010) BARDEC=0 -> delivered; MRd BARDEC=6'b000010 -> dropped, DROP_COUNT increments by 1.
- READY=0, DEPTH=64, stream 2-beat TLPs -> TL_RX_WAIT=1 once 60 beats stored; force 65th beat -> OVERFLOW=1, partial TLP discarded, 32 committed TLPs then read intact, in order.
- TLP A beat 1 (SOP, no EOP) then TLP B SOP+EOP -> only B delivered, DROP_COUNT=1.
- RST pulsed after beat 1 of 3-beat TLP -> all outputs at reset values, no beats from that TLP appear after release.
